cache_arbiter_buffer: RTL and testbench

CACHE_ARBITER_BUFFER -- requirements
Module: cache_arbiter_buffer

---
 rtl/cache_arbiter_buffer_pkg.sv | 13 +
 rtl/cache_arbiter_buffer_if.sv | 42 ++++
 rtl/cache_arbiter_buffer_regs.sv | 57 +++++
 rtl/cache_arbiter_buffer.sv | 142 ++++++++++++++
 tb/tb_cache_arbiter_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_arbiter_buffer_pkg.sv
// Shared definitions for the cache-to-L2 arbiter buffer: default widths and
// the request owner encoding used by the capture registers and the FSM.
package cache_arbiter_buffer_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LINE_W_DEF = 256;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

endpackage

// File: rtl/cache_arbiter_buffer_if.sv
// Bundle of I-cache, D-cache, L2 and arbiter-control signals seen by the buffer.
// The slave view belongs to the buffer; the master view to its environment.
interface cache_arbiter_buffer_if
   import cache_arbiter_buffer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
);

   logic              i_read_in;
   logic [ADDR_W-1:0] i_addr_in;
   logic              d_read_in;
   logic              d_write_in;
   logic [ADDR_W-1:0] d_addr_in;
   logic [LINE_W-1:0] d_wdata_in;
   logic              i_resp_out;
   logic [LINE_W-1:0] i_rdata_out;
   logic              d_resp_out;
   logic [LINE_W-1:0] d_rdata_out;
   logic              l2_read_out;
   logic              l2_write_out;
   logic [ADDR_W-1:0] l2_addr_out;
   logic [LINE_W-1:0] l2_wdata_out;
   logic              l2_resp_in;
   logic [LINE_W-1:0] l2_rdata_in;
   logic              arb_resp_out;

   modport slave (
      input  i_read_in, i_addr_in, d_read_in, d_write_in, d_addr_in, d_wdata_in,
      input  l2_resp_in, l2_rdata_in,
      output i_resp_out, i_rdata_out, d_resp_out, d_rdata_out,
      output l2_read_out, l2_write_out, l2_addr_out, l2_wdata_out, arb_resp_out
   );

   modport master (
      output i_read_in, i_addr_in, d_read_in, d_write_in, d_addr_in, d_wdata_in,
      output l2_resp_in, l2_rdata_in,
      input  i_resp_out, i_rdata_out, d_resp_out, d_rdata_out,
      input  l2_read_out, l2_write_out, l2_addr_out, l2_wdata_out, arb_resp_out
   );

endinterface

// File: rtl/cache_arbiter_buffer_regs.sv
// Capture registers for the in-flight request (address, write line, direction,
// owner) and the returned-line register shared by both caches.
module cache_arbiter_buffer_regs
   import cache_arbiter_buffer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_en_i,
   input  logic              cap_write_i,
   input  owner_e            cap_owner_i,
   input  logic [ADDR_W-1:0] cap_addr_i,
   input  logic [LINE_W-1:0] cap_wdata_i,
   input  logic              line_en_i,
   input  logic [LINE_W-1:0] line_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [LINE_W-1:0] wdata_o,
   output logic              write_o,
   output owner_e            owner_o,
   output logic [LINE_W-1:0] line_o
);

   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              write_q;
   owner_e            owner_q;
   logic [LINE_W-1:0] line_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         owner_q <= OWNER_I;
         line_q  <= '0;
      end else begin
         if (cap_en_i) begin
            addr_q  <= cap_addr_i;
            wdata_q <= cap_wdata_i;
            write_q <= cap_write_i;
            owner_q <= cap_owner_i;
         end
         if (line_en_i) begin
            line_q <= line_i;
         end
      end
   end

   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign write_o = write_q;
   assign owner_o = owner_q;
   assign line_o  = line_q;

endmodule

// File: rtl/cache_arbiter_buffer.sv
// Single-outstanding L2 request buffer between I/D caches and L2, D before I.
// FSM issues captured request, waits for L2, then pulses the owner's response.
module cache_arbiter_buffer
   import cache_arbiter_buffer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input logic                    clk,
   input logic                    rst,
   cache_arbiter_buffer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } state_e;

   state_e state_q;
   logic   rd_q;
   logic   wr_q;
   logic   i_resp_q;
   logic   d_resp_q;
   logic   arb_resp_q;

   logic              d_req;
   logic              d_is_write;
   logic              cap_en_d;
   logic              cap_write_d;
   owner_e            cap_owner_d;
   logic [ADDR_W-1:0] cap_addr_d;
   logic [LINE_W-1:0] cap_wdata_d;
   logic              line_en_d;

   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              write_q;
   owner_e            owner_q;
   logic [LINE_W-1:0] line_q;

   assign d_req      = bus.d_read_in | bus.d_write_in;
   // A simultaneous read+write from the D side is a write-back.
   assign d_is_write = bus.d_write_in;

   always_comb begin
      cap_en_d    = 1'b0;
      cap_write_d = 1'b0;
      cap_owner_d = OWNER_I;
      cap_addr_d  = '0;
      cap_wdata_d = '0;
      if (state_q == IDLE) begin
         if (d_req) begin
            cap_en_d    = 1'b1;
            cap_write_d = d_is_write;
            cap_owner_d = OWNER_D;
            cap_addr_d  = bus.d_addr_in;
            cap_wdata_d = bus.d_wdata_in;
         end else if (bus.i_read_in) begin
            cap_en_d    = 1'b1;
            cap_owner_d = OWNER_I;
            cap_addr_d  = bus.i_addr_in;
         end
      end
   end

   assign line_en_d = (state_q == ISSUE) && bus.l2_resp_in && !write_q;

   cache_arbiter_buffer_regs #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) u_regs (
      .clk         (clk),
      .rst         (rst),
      .cap_en_i    (cap_en_d),
      .cap_write_i (cap_write_d),
      .cap_owner_i (cap_owner_d),
      .cap_addr_i  (cap_addr_d),
      .cap_wdata_i (cap_wdata_d),
      .line_en_i   (line_en_d),
      .line_i      (bus.l2_rdata_in),
      .addr_o      (addr_q),
      .wdata_o     (wdata_q),
      .write_o     (write_q),
      .owner_o     (owner_q),
      .line_o      (line_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         i_resp_q   <= 1'b0;
         d_resp_q   <= 1'b0;
         arb_resp_q <= 1'b0;
      end else begin
         i_resp_q   <= 1'b0;
         d_resp_q   <= 1'b0;
         arb_resp_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cap_en_d) begin
                  state_q <= ISSUE;
                  rd_q    <= !cap_write_d;
                  wr_q    <= cap_write_d;
               end
            end
            ISSUE: begin
               // Request lines are not consulted here: a dropped request still completes.
               if (bus.l2_resp_in) begin
                  state_q    <= RESPOND;
                  rd_q       <= 1'b0;
                  wr_q       <= 1'b0;
                  i_resp_q   <= (owner_q == OWNER_I);
                  d_resp_q   <= (owner_q == OWNER_D);
                  arb_resp_q <= 1'b1;
               end
            end
            RESPOND: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.l2_read_out  = rd_q;
   assign bus.l2_write_out = wr_q;
   assign bus.l2_addr_out  = addr_q;
   assign bus.l2_wdata_out = wdata_q;
   assign bus.i_resp_out   = i_resp_q;
   assign bus.d_resp_out   = d_resp_q;
   assign bus.arb_resp_out = arb_resp_q;
   assign bus.i_rdata_out  = line_q;
   assign bus.d_rdata_out  = line_q;

endmodule

// File: tb/tb_cache_arbiter_buffer.sv
// Directed bench for cache_arbiter_buffer: D/I reads, priority, write-back,
// mid-transaction reset and spurious L2 responses, with hand-computed expectations.
module tb_cache_arbiter_buffer;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   logic [LINE_W-1:0] line_a5;
   logic [LINE_W-1:0] line_11;
   logic [LINE_W-1:0] line_22;
   logic [LINE_W-1:0] line_ff;
   logic [LINE_W-1:0] line_5a;
   logic [LINE_W-1:0] line_de;
   logic [LINE_W-1:0] line_wb;

   cache_arbiter_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   cache_arbiter_buffer #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LINE_W-1:0] act,
                      input logic [LINE_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_strobes(input string tag, input logic rd, input logic wr);
      chk({tag, ".l2_read"},  LINE_W'(bus.l2_read_out),  LINE_W'(rd));
      chk({tag, ".l2_write"}, LINE_W'(bus.l2_write_out), LINE_W'(wr));
   endtask

   task automatic chk_resp(input string tag, input logic ir, input logic dr, input logic ar);
      chk({tag, ".i_resp"},   LINE_W'(bus.i_resp_out),   LINE_W'(ir));
      chk({tag, ".d_resp"},   LINE_W'(bus.d_resp_out),   LINE_W'(dr));
      chk({tag, ".arb_resp"}, LINE_W'(bus.arb_resp_out), LINE_W'(ar));
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      line_a5 = {32{8'hA5}};
      line_11 = {32{8'h11}};
      line_22 = {32{8'h22}};
      line_ff = {32{8'hFF}};
      line_5a = {32{8'h5A}};
      line_de = {8{32'hDEADBEEF}};
      line_wb = {8{32'h12345678}};

      bus.i_read_in   = 1'b0;
      bus.i_addr_in   = '0;
      bus.d_read_in   = 1'b0;
      bus.d_write_in  = 1'b0;
      bus.d_addr_in   = '0;
      bus.d_wdata_in  = '0;
      bus.l2_resp_in  = 1'b0;
      bus.l2_rdata_in = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk_strobes("rst", 1'b0, 1'b0);
      chk_resp("rst", 1'b0, 1'b0, 1'b0);
      chk("rst.l2_addr", LINE_W'(bus.l2_addr_out), '0);
      chk("rst.l2_wdata", bus.l2_wdata_out, '0);
      chk("rst.d_rdata", bus.d_rdata_out, '0);

      // D read 0x1000, L2 answers in the third ISSUE cycle; request dropped early
      bus.d_read_in = 1'b1;
      bus.d_addr_in = 32'h0000_1000;
      tick();
      bus.d_read_in = 1'b0;
      bus.d_addr_in = 32'h0000_BEEF;
      chk_strobes("dr.iss1", 1'b1, 1'b0);
      chk("dr.addr1", LINE_W'(bus.l2_addr_out), LINE_W'(32'h0000_1000));
      chk_resp("dr.iss1", 1'b0, 1'b0, 1'b0);
      tick();
      chk_strobes("dr.iss2", 1'b1, 1'b0);
      chk("dr.addr2", LINE_W'(bus.l2_addr_out), LINE_W'(32'h0000_1000));
      tick();
      chk_strobes("dr.iss3", 1'b1, 1'b0);
      bus.l2_resp_in  = 1'b1;
      bus.l2_rdata_in = line_a5;
      tick();
      bus.l2_resp_in  = 1'b0;
      bus.l2_rdata_in = '0;
      chk_strobes("dr.resp", 1'b0, 1'b0);
      chk_resp("dr.resp", 1'b0, 1'b1, 1'b1);
      chk("dr.d_rdata", bus.d_rdata_out, line_a5);
      chk("dr.i_rdata", bus.i_rdata_out, line_a5);
      tick();
      chk_resp("dr.idle", 1'b0, 1'b0, 1'b0);
      chk("dr.hold", bus.d_rdata_out, line_a5);

      // D and I together: D first, I only captured after RESPOND -> IDLE
      bus.d_read_in = 1'b1;
      bus.d_addr_in = 32'h0000_3000;
      bus.i_read_in = 1'b1;
      bus.i_addr_in = 32'h0000_0080;
      tick();
      bus.d_read_in = 1'b0;
      chk_strobes("pri.iss", 1'b1, 1'b0);
      chk("pri.addr_d", LINE_W'(bus.l2_addr_out), LINE_W'(32'h0000_3000));
      bus.l2_resp_in  = 1'b1;
      bus.l2_rdata_in = line_11;
      tick();
      bus.l2_resp_in = 1'b0;
      chk_resp("pri.dresp", 1'b0, 1'b1, 1'b1);
      chk("pri.d_line", bus.d_rdata_out, line_11);
      tick();
      chk_strobes("pri.idle", 1'b0, 1'b0);
      chk_resp("pri.idle", 1'b0, 1'b0, 1'b0);
      tick();
      bus.i_read_in = 1'b0;
      chk_strobes("pri.iiss", 1'b1, 1'b0);
      chk("pri.addr_i", LINE_W'(bus.l2_addr_out), LINE_W'(32'h0000_0080));
      bus.l2_resp_in  = 1'b1;
      bus.l2_rdata_in = line_22;
      tick();
      bus.l2_resp_in = 1'b0;
      chk_resp("pri.iresp", 1'b1, 1'b0, 1'b1);
      chk("pri.i_line", bus.i_rdata_out, line_22);
      tick();

      // D write-back (read+write both high counts as write); line register untouched
      bus.d_read_in  = 1'b1;
      bus.d_write_in = 1'b1;
      bus.d_addr_in  = 32'h0000_2040;
      bus.d_wdata_in = line_wb;
      tick();
      bus.d_read_in  = 1'b0;
      bus.d_write_in = 1'b0;
      bus.d_wdata_in = '0;
      chk_strobes("wb.iss", 1'b0, 1'b1);
      chk("wb.addr", LINE_W'(bus.l2_addr_out), LINE_W'(32'h0000_2040));
      chk("wb.wdata", bus.l2_wdata_out, line_wb);
      bus.l2_resp_in  = 1'b1;
      bus.l2_rdata_in = line_ff;
      tick();
      bus.l2_resp_in = 1'b0;
      chk_strobes("wb.resp", 1'b0, 1'b0);
      chk_resp("wb.resp", 1'b0, 1'b1, 1'b1);
      chk("wb.d_rdata", bus.d_rdata_out, line_22);
      tick();
      chk("wb.hold", bus.d_rdata_out, line_22);

      // Reset during the second ISSUE cycle discards the transaction
      bus.d_read_in = 1'b1;
      bus.d_addr_in = 32'h0000_4000;
      tick();
      bus.d_read_in = 1'b0;
      tick();
      chk_strobes("rsti.iss2", 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_strobes("rsti.after", 1'b0, 1'b0);
      chk("rsti.addr", LINE_W'(bus.l2_addr_out), '0);
      chk("rsti.line", bus.d_rdata_out, '0);
      bus.l2_resp_in  = 1'b1;
      bus.l2_rdata_in = line_ff;
      tick();
      bus.l2_resp_in = 1'b0;
      chk_resp("rsti.noresp", 1'b0, 1'b0, 1'b0);
      chk_strobes("rsti.idle", 1'b0, 1'b0);
      chk("rsti.line2", bus.d_rdata_out, '0);

      // Request present only during the reset cycle is not captured
      rst = 1'b1;
      bus.d_read_in = 1'b1;
      bus.d_addr_in = 32'h0000_5000;
      tick();
      rst = 1'b0;
      bus.d_read_in = 1'b0;
      tick();
      chk_strobes("rstreq", 1'b0, 1'b0);

      // Spurious L2 response in IDLE, then normal I read 0x40
      bus.l2_resp_in  = 1'b1;
      bus.l2_rdata_in = line_de;
      tick();
      bus.l2_resp_in = 1'b0;
      chk_resp("spur", 1'b0, 1'b0, 1'b0);
      chk("spur.line", bus.i_rdata_out, '0);
      bus.i_read_in = 1'b1;
      bus.i_addr_in = 32'h0000_0040;
      tick();
      bus.i_read_in = 1'b0;
      chk_strobes("ir.iss", 1'b1, 1'b0);
      chk("ir.addr", LINE_W'(bus.l2_addr_out), LINE_W'(32'h0000_0040));
      bus.l2_resp_in  = 1'b1;
      bus.l2_rdata_in = line_5a;
      tick();
      // Keep L2 response high through RESPOND: must be ignored
      bus.l2_rdata_in = line_de;
      chk_resp("ir.resp", 1'b1, 1'b0, 1'b1);
      chk("ir.line", bus.i_rdata_out, line_5a);
      tick();
      bus.l2_resp_in = 1'b0;
      chk_resp("ir.idle", 1'b0, 1'b0, 1'b0);
      chk_strobes("ir.idle", 1'b0, 1'b0);
      chk("ir.hold", bus.i_rdata_out, line_5a);
      tick();
      chk_resp("ir.idle2", 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
